// File: rtl/tx_crc_gen_pkg.sv
// Shared MAC definitions: Ethernet CRC-32 step function, preset, default
// minimum frame length and the TX FCS generator state encoding.
package tx_crc_gen_pkg;

    localparam logic [31:0] CRC_PRESET      = 32'hFFFF_FFFF;
    // Polynomial 0x04C11DB7 bit-reversed, for LSB-first processing
    localparam logic [31:0] CRC_POLY_REFL   = 32'hEDB8_8320;
    localparam int          DEFAULT_MIN_LEN = 60;

    typedef enum logic [1:0] {
        DATA = 2'd0,
        PAD  = 2'd1,
        FCS  = 2'd2
    } tx_state_e;

    function automatic logic [31:0] crc32_next(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY_REFL;
            else                c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/tx_crc_gen_if.sv
// Byte-stream bus around the TX FCS generator: framer-side input channel
// and PHY-side output channel, each with valid/ready flow control.
interface tx_crc_gen_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_eop;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_eop;
    logic       out_ready;

    modport master (
        output in_data, in_valid, in_eop, out_ready,
        input  in_ready, out_data, out_valid, out_eop
    );

    modport slave (
        input  in_data, in_valid, in_eop, out_ready,
        output in_ready, out_data, out_valid, out_eop
    );

endinterface

// File: rtl/tx_crc_gen.sv
// TX frame check sequence generator: passes frame bytes through, zero-pads
// short frames to MIN_LEN and appends the Ethernet CRC-32, LSB byte first.
module tx_crc_gen
    import tx_crc_gen_pkg::*;
#(
    parameter int MIN_LEN = DEFAULT_MIN_LEN,
    parameter bit PAD_EN  = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            crc_append,
    tx_crc_gen_if.slave     bus
);

    localparam logic [10:0] MIN_LEN_C = 11'(MIN_LEN);

    tx_state_e   state_q, state_d;
    logic [31:0] crc_q,   crc_d;
    logic [10:0] cnt_q,   cnt_d;
    logic [1:0]  k_q,     k_d;
    logic        append_q, append_d;

    logic        valid_c, ready_c, eop_c;
    logic [7:0]  data_c;
    logic [31:0] fcs;
    logic [10:0] cnt_inc, cnt_sat;
    logic        first_byte, append_eff, pad_go, last_pad, frame_done;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path infers a latch.
        state_d    = state_q;
        crc_d      = crc_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        append_d   = append_q;
        valid_c    = 1'b0;
        ready_c    = 1'b0;
        eop_c      = 1'b0;
        data_c     = 8'h00;
        frame_done = 1'b0;

        fcs        = ~crc_q;
        cnt_inc    = cnt_q + 11'd1;
        cnt_sat    = (cnt_q < MIN_LEN_C) ? cnt_inc : cnt_q;
        first_byte = (cnt_q == 11'd0);
        // The append bit of a frame is taken from its first byte, even for 1-byte frames
        append_eff = first_byte ? crc_append : append_q;
        pad_go     = PAD_EN && (cnt_inc < MIN_LEN_C);
        last_pad   = (cnt_inc == MIN_LEN_C);

        unique case (state_q)
            DATA: begin
                valid_c = bus.in_valid;
                ready_c = bus.out_ready;
                data_c  = bus.in_data;
                eop_c   = bus.in_valid && bus.in_eop && !pad_go && !append_eff;
                if (bus.in_valid && bus.out_ready) begin
                    crc_d = crc32_next(crc_q, bus.in_data);
                    cnt_d = cnt_sat;
                    if (first_byte) append_d = crc_append;
                    if (bus.in_eop) begin
                        if (pad_go)          state_d    = PAD;
                        else if (append_eff) state_d    = FCS;
                        else                 frame_done = 1'b1;
                    end
                end
            end

            PAD: begin
                valid_c = 1'b1;
                eop_c   = last_pad && !append_q;
                if (bus.out_ready) begin
                    crc_d = crc32_next(crc_q, 8'h00);
                    cnt_d = cnt_inc;
                    if (last_pad) begin
                        if (append_q) state_d    = FCS;
                        else          frame_done = 1'b1;
                    end
                end
            end

            FCS: begin
                valid_c = 1'b1;
                data_c  = fcs[{k_q, 3'b000} +: 8];
                eop_c   = (k_q == 2'd3);
                if (bus.out_ready) begin
                    k_d = k_q + 2'd1;
                    if (k_q == 2'd3) frame_done = 1'b1;
                end
            end

            default: frame_done = 1'b1;
        endcase

        if (frame_done) begin
            state_d = DATA;
            crc_d   = CRC_PRESET;
            cnt_d   = 11'd0;
            k_d     = 2'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= DATA;
            crc_q    <= CRC_PRESET;
            cnt_q    <= 11'd0;
            k_q      <= 2'd0;
            append_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            crc_q    <= crc_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            append_q <= append_d;
        end
    end

    // Reset blanks the byte interface immediately, aborting any frame in flight
    assign bus.out_valid = valid_c & ~rst;
    assign bus.in_ready  = ready_c & ~rst;
    assign bus.out_eop   = eop_c & ~rst;
    assign bus.out_data  = rst ? 8'h00 : data_c;

endmodule

// File: tb/tb_tx_crc_gen.sv
// Self-checking bench for tx_crc_gen: table-driven frames, hand-written reset
// and back-to-back sequences, and randomized streams against a byte-level model.
module tb_tx_crc_gen;

    typedef logic [7:0] byte_t;

    typedef struct {
        string       name;
        int          kind;        // 0: "123456789" pattern, 1: zeros, 2: random
        int          len;
        bit          use_pad;
        bit          append;
        bit          stall;
        bit          toggle;
        int          exp_total;
        int          exp_cycles;  // -1 = not checked
        int          exp_ready_low;
        logic [31:0] exp_fcs;
        bit          chk_fcs;
        bit          residue;
    } vec_t;

    localparam int MIN_LEN = 60;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  crc_append = 1'b1;
    logic  in_valid = 1'b0;
    logic  in_eop = 1'b0;
    logic  out_ready = 1'b0;
    byte_t in_data = 8'h00;
    bit    sel_pad = 1'b1;

    always #5 clk = ~clk;

    tx_crc_gen_if bus_p ();
    tx_crc_gen_if bus_n ();

    assign bus_p.in_data   = in_data;
    assign bus_p.in_valid  = in_valid;
    assign bus_p.in_eop    = in_eop;
    assign bus_p.out_ready = out_ready;
    assign bus_n.in_data   = in_data;
    assign bus_n.in_valid  = in_valid;
    assign bus_n.in_eop    = in_eop;
    assign bus_n.out_ready = out_ready;

    tx_crc_gen #(.MIN_LEN(MIN_LEN), .PAD_EN(1'b1)) dut_p (
        .clk(clk), .rst(rst), .crc_append(crc_append), .bus(bus_p));
    tx_crc_gen #(.MIN_LEN(MIN_LEN), .PAD_EN(1'b0)) dut_n (
        .clk(clk), .rst(rst), .crc_append(crc_append), .bus(bus_n));

    logic  s_out_valid, s_out_eop, s_in_ready;
    byte_t s_out_data;
    assign s_out_valid = sel_pad ? bus_p.out_valid : bus_n.out_valid;
    assign s_out_eop   = sel_pad ? bus_p.out_eop   : bus_n.out_eop;
    assign s_in_ready  = sel_pad ? bus_p.in_ready  : bus_n.in_ready;
    assign s_out_data  = sel_pad ? bus_p.out_data  : bus_n.out_data;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: table-driven software CRC-32 over whole byte arrays
    logic [31:0] crc_tab [256];

    function automatic logic [31:0] crc_run(input logic [31:0] c0, input byte_t q[$]);
        logic [31:0] c;
        c = c0;
        foreach (q[i]) c = (c >> 8) ^ crc_tab[8'(c[7:0] ^ q[i])];
        return c;
    endfunction

    function automatic logic [31:0] bit_rev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    byte_t exp_d[$];
    bit    exp_e[$];

    task automatic model_frame(input byte_t f[$], input bit pad_en, input bit app);
        byte_t       o[$];
        logic [31:0] f_val;
        o = f;
        if (pad_en) while (o.size() < MIN_LEN) o.push_back(8'h00);
        if (app) begin
            f_val = ~crc_run(32'hFFFF_FFFF, o);
            for (int k = 0; k < 4; k++) o.push_back(f_val[8*k +: 8]);
        end
        foreach (o[i]) begin
            exp_d.push_back(o[i]);
            exp_e.push_back(i == o.size() - 1);
        end
    endtask

    // Stream driver/monitor state
    byte_t st_d[$];
    bit    st_e[$];
    int    nframes;
    byte_t got_d[$];
    bit    got_e[$];
    int    eop_cyc[$];
    int    in_cyc[$];
    int    run_cycles, ready_low, hold_err;

    task automatic run_stream(input string name, input bit stall, input bit toggle);
        int    idx, eops, cyc;
        bit    pend, pe;
        byte_t pd;
        idx = 0; eops = 0; cyc = 0; pend = 0; pe = 0; pd = 8'h00;
        got_d.delete(); got_e.delete(); eop_cyc.delete(); in_cyc.delete();
        ready_low = 0; hold_err = 0;
        while (eops < nframes && cyc < 5000) begin
            @(negedge clk);
            in_valid  = (idx < st_d.size());
            in_data   = in_valid ? st_d[idx] : 8'h00;
            in_eop    = in_valid ? st_e[idx] : 1'b0;
            out_ready = stall ? ($urandom_range(0, 99) >= 30) : 1'b1;
            if (toggle && idx > 0) crc_append = 1'($urandom_range(0, 1));
            #1;
            if (pend && (s_out_data !== pd || s_out_eop !== pe || s_out_valid !== 1'b1))
                hold_err++;
            pend = s_out_valid && !out_ready;
            pd   = s_out_data;
            pe   = s_out_eop;
            if (idx > 0 && !s_in_ready) ready_low++;
            if (s_out_valid && out_ready) begin
                got_d.push_back(s_out_data);
                got_e.push_back(s_out_eop);
                if (s_out_eop) begin
                    eops++;
                    eop_cyc.push_back(cyc);
                end
            end
            if (in_valid && s_in_ready) begin
                in_cyc.push_back(cyc);
                idx++;
            end
            cyc++;
        end
        run_cycles = cyc;
        @(negedge clk);
        in_valid = 1'b0; in_eop = 1'b0; out_ready = 1'b0;
        check({name, "_frames_done"}, 32'(eops), 32'(nframes));
    endtask

    task automatic compare_stream(input string name);
        int dmis, emis, n;
        dmis = 0; emis = 0;
        n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
        for (int i = 0; i < n; i++) begin
            if (got_d[i] !== exp_d[i]) dmis++;
            if (got_e[i] !== exp_e[i]) emis++;
        end
        check({name, "_out_len"}, 32'(got_d.size()), 32'(exp_d.size()));
        check({name, "_data_mismatches"}, 32'(dmis), 32'd0);
        check({name, "_eop_mismatches"}, 32'(emis), 32'd0);
        if (hold_err != 0) check({name, "_stall_hold"}, 32'(hold_err), 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_eop = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_frame(input int kind, input int len, input bit clear);
        if (clear) begin
            st_d.delete(); st_e.delete(); nframes = 0;
        end
        for (int i = 0; i < len; i++) begin
            case (kind)
                0:       st_d.push_back(8'(8'h31 + i));
                1:       st_d.push_back(8'h00);
                default: st_d.push_back(8'($urandom_range(0, 255)));
            endcase
            st_e.push_back(i == len - 1);
        end
        nframes++;
    endtask

    task automatic model_stream(input bit pad_en, input bit app);
        byte_t f[$];
        exp_d.delete(); exp_e.delete();
        foreach (st_d[i]) begin
            f.push_back(st_d[i]);
            if (st_e[i]) begin
                model_frame(f, pad_en, app);
                f.delete();
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input bit do_reset);
        logic [31:0] got_fcs;
        int          n;
        sel_pad    = v.use_pad;
        crc_append = v.append;
        if (do_reset) apply_reset();
        load_frame(v.kind, v.len, 1'b1);
        model_stream(v.use_pad, v.append);
        run_stream(v.name, v.stall, v.toggle);
        crc_append = 1'b1;
        compare_stream(v.name);
        check({v.name, "_total"}, 32'(got_d.size()), 32'(v.exp_total));
        if (v.exp_cycles >= 0)
            check({v.name, "_cycles"}, 32'(run_cycles), 32'(v.exp_cycles));
        if (v.exp_ready_low >= 0)
            check({v.name, "_in_ready_low"}, 32'(ready_low), 32'(v.exp_ready_low));
        n = got_d.size();
        if (v.chk_fcs && n >= 4) begin
            got_fcs = {got_d[n-1], got_d[n-2], got_d[n-3], got_d[n-4]};
            check({v.name, "_fcs"}, got_fcs, v.exp_fcs);
        end
        if (v.residue)
            check({v.name, "_residue"}, bit_rev(crc_run(32'hFFFF_FFFF, got_d)), 32'hC704_DD7B);
    endtask

    vec_t vecs [7];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int n = 0; n < 256; n++) begin
            logic [31:0] c;
            c = 32'(n);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            crc_tab[n] = c;
        end

        //        name            kind len pad app  stl  tog  tot cyc rdy  fcs           chk  res
        vecs[0] = '{"ascii_nopad",   0,  9, 1'b0, 1'b1, 1'b0, 1'b0, 13, 13,  4, 32'hCBF43926, 1'b1, 1'b1};
        vecs[1] = '{"one_byte",      1,  1, 1'b1, 1'b1, 1'b0, 1'b0, 64, 64, 63, 32'h0,        1'b0, 1'b1};
        vecs[2] = '{"rand64_stall",  2, 64, 1'b1, 1'b1, 1'b1, 1'b0, 68, -1, -1, 32'h0,        1'b0, 1'b1};
        vecs[3] = '{"noapp_toggle",  2, 10, 1'b1, 1'b0, 1'b0, 1'b1, 60, 60, 50, 32'h0,        1'b0, 1'b0};
        vecs[4] = '{"exact_min",     2, 60, 1'b1, 1'b1, 1'b0, 1'b0, 64, 64,  4, 32'h0,        1'b0, 1'b1};
        vecs[5] = '{"min_minus1",    2, 59, 1'b1, 1'b1, 1'b0, 1'b0, 64, 64,  5, 32'h0,        1'b0, 1'b1};
        vecs[6] = '{"long_nopad",    2, 70, 1'b0, 1'b0, 1'b1, 1'b0, 70, -1, -1, 32'h0,        1'b0, 1'b0};

        // Outputs while reset is held, with live-looking inputs
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hA5; in_eop = 1'b1; out_ready = 1'b1;
        #1;
        check("rst_p_out_valid", 32'(bus_p.out_valid), 32'd0);
        check("rst_p_in_ready",  32'(bus_p.in_ready),  32'd0);
        check("rst_p_out_eop",   32'(bus_p.out_eop),   32'd0);
        check("rst_p_out_data",  32'(bus_p.out_data),  32'd0);
        check("rst_n_out_valid", 32'(bus_n.out_valid), 32'd0);
        check("rst_n_in_ready",  32'(bus_n.in_ready),  32'd0);
        @(negedge clk);
        in_valid = 1'b0; in_eop = 1'b0; out_ready = 1'b0;
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], 1'b1);

        // Reset pulsed while FCS byte k=1 is being presented
        sel_pad = 1'b0; crc_append = 1'b1;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid  = (i < 9);
            in_data   = 8'(8'h31 + i);
            in_eop    = (i == 8);
            out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0; in_eop = 1'b0; out_ready = 1'b0;
        #1;
        check("midfcs_valid_before_rst", 32'(s_out_valid), 32'd1);
        check("midfcs_k1_byte", 32'(s_out_data), 32'h39);
        rst = 1'b1;
        #1;
        check("midfcs_valid_in_rst", 32'(s_out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(vecs[0], 1'b0);

        // Back-to-back frames with in_valid held high
        sel_pad = 1'b0; crc_append = 1'b1;
        apply_reset();
        load_frame(0, 9, 1'b1);
        load_frame(2, 12, 1'b0);
        model_stream(1'b0, 1'b1);
        run_stream("b2b", 1'b0, 1'b0);
        compare_stream("b2b");
        if (eop_cyc.size() >= 1 && in_cyc.size() >= 10)
            check("b2b_second_start", 32'(in_cyc[9]), 32'(eop_cyc[0] + 1));
        else
            check("b2b_progress", 32'(in_cyc.size()), 32'd21);

        // Randomized multi-frame streams with stalls on the padding instance
        sel_pad = 1'b1;
        apply_reset();
        for (int r = 0; r < 5; r++) begin
            crc_append = 1'($urandom_range(0, 1));
            load_frame(2, $urandom_range(1, 80), 1'b1);
            load_frame(2, $urandom_range(1, 80), 1'b0);
            load_frame(2, $urandom_range(1, 80), 1'b0);
            model_stream(1'b1, crc_append);
            run_stream($sformatf("rand%0d", r), 1'b1, 1'b0);
            compare_stream($sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
